dec_scan_ctrl: RTL and testbench
================================

// Module: dec_scan_ctrl
// PURPOSE
//   Upstream driver for the dec3to8 decoders: generates the 3-bit select code and the enable.
//   Steps a select index through NUM_DIG slots, one slot every DIV clocks, wrapping continuously.
//   Used for multiplexed digit/LED scanning.
//   Optional inter-slot blanking holds the enable low for BLANK clocks to suppress ghosting.
// PARAMETERS
//   DIV      1000  clocks per slot; legal range BLANK+1 .. 2**CNT_W-1
//   NUM_DIG  8     active slots per frame, 1..8
//   BLANK    4     blanked clocks at start of each slot (used only with SCAN_BLANK_EN)
//   CNT_W    16    slot-counter width
// PORTS
//   One clock; reset is asynchronous and active-high.
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous active-high reset
//   run         in   1  level; 1 = scan, 0 = stop
//   sel         out  3  select code to decoder in[2:0]
//   sel_en      out  1  decoder enable
//   frame_done  out  1  one-clock pulse on the wrap to slot 0
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset (async, any time, including mid-slot): state=IDLE, sel=0, sel_en=0, frame_done=0, cnt=0.
//   - FSM states: IDLE, BLANK, DRIVE. cnt counts 0..DIV-1 within a slot.
//   - IDLE: sel=0, sel_en=0. When run=1 at an edge, the next cycle enters slot 0 with cnt=0:
//     BLANK if SCAN_BLANK_EN is defined, otherwise DRIVE.
//   - BLANK: sel_en=0. When cnt==BLANK-1, go to DRIVE.
//   - DRIVE: sel_en=1.
//   - Slot end (cnt==DIV-1): cnt=0; sel = (sel==NUM_DIG-1) ? 0 : sel+1; state becomes BLANK/DRIVE per the macro.
//   - frame_done=1 only in the first cycle of a slot reached by wrapping from NUM_DIG-1 to 0.
//     Never asserted on the initial start from IDLE.
//   - NUM_DIG=1: sel stays 0; frame_done pulses every DIV clocks after the first slot.
//   - run=0 at any edge: next cycle state=IDLE, sel=0, sel_en=0, cnt=0, frame_done=0.
//     A slot in progress is abandoned. A later run=1 restarts from slot 0 with no frame_done.
//   - run=1 in the same cycle as a slot end: normal advance. run=0 has priority over slot end.
//   - sel never exceeds NUM_DIG-1. Width: cnt is CNT_W bits and never wraps beyond DIV-1.
//   - sel and sel_en change on the same edge. With blanking, sel changes only while sel_en=0.
// CONFIGURATION
//   SCAN_BLANK_EN defined:
//     - Each slot = BLANK clocks with sel_en=0, then DIV-BLANK clocks with sel_en=1.
//     - BLANK>=1 is required.
//   SCAN_BLANK_EN undefined:
//     - BLANK state is not built; each slot = DIV clocks with sel_en=1.
//     - sel changes while enabled.
// TESTING
//   Bench config: DIV=4, BLANK=1, NUM_DIG=3, clk period 200.
//   1 Reset: rst=1 mid-run at a non-edge time -> sel=000, sel_en=0, frame_done=0 immediately, before the next clk edge.
//   2 Start, blank on: run=1 -> from next cycle:
//     sel 0,0,0,0,1,1,1,1,2,2,2,2,0...; sel_en 0,1,1,1 repeating;
//     frame_done=1 only at clock 13 (first cycle of second slot 0).
//   3 Start, blank off: same stimulus -> sel_en=1 on every cycle after start;
//     sel sequence and frame_done timing identical to scenario 2.
//   4 Stop mid-slot: run=0 while sel=1, cnt=2 -> next cycle sel=0, sel_en=0, held.
//     Re-assert run -> slot 0 restarts, no frame_done.
//   5 NUM_DIG=1, DIV=4: sel stays 000; frame_done pulses at clocks 5, 9, 13...
//   6 Decoder pairing: drive dec3to8 from sel/sel_en -> exactly one-hot out equal to 1<<sel while sel_en=1;
//     out all zero during BLANK.

Source files
------------

// File: rtl/dec_scan_ctrl.sv
// dec_scan_ctrl: scan sequencer that drives the select code and enable of a dec3to8 decoder.
// The select index steps through NUM_DIG slots. Each slot lasts DIV clocks, and the index
// wraps continuously. frame_done pulses for one clock when the index wraps back to slot 0.
// Optional feature macro: SCAN_BLANK_EN. When it is defined, the first BLANK clocks of every
// slot keep the enable low, so that the select code only moves while the decoder is dark.
module dec_scan_ctrl #(
    parameter int DIV     = 1000,
    parameter int NUM_DIG = 8,
    parameter int BLANK   = 4,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic [2:0] sel,
    output logic       sel_en,
    output logic       frame_done
);

    // Reject parameter sets that would let cnt or sel leave their legal ranges.
    if ((DIV < BLANK + 1) || (DIV > (2 ** CNT_W) - 1) || (NUM_DIG < 1) || (NUM_DIG > 8)) begin : g_bad_cfg
        $error("dec_scan_ctrl: illegal DIV/BLANK/NUM_DIG/CNT_W combination");
    end

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    // Every slot opens dark.
    localparam state_t             SLOT_START = ST_BLANK;
    localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK - 1);
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd2
    } state_t;

    // Without blanking, every slot is driven from its first clock.
    localparam state_t             SLOT_START = ST_DRIVE;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [2:0]       LAST_SEL = 3'(NUM_DIG - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [2:0]       sel_r;
    logic [2:0]       sel_nxt_s;
    logic             sel_en_r;
    logic             sel_en_nxt_s;
    logic             frame_done_r;
    logic             frame_done_nxt_s;

    // Next-state logic. run=0 overrides everything, including a slot end on the same clock.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        sel_nxt_s        = sel_r;
        frame_done_nxt_s = 1'b0;
        if (!run) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
            sel_nxt_s   = 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A start from idle always begins at slot 0 and never reports a frame.
                    state_nxt_s = SLOT_START;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    sel_nxt_s   = 3'd0;
                end
`ifdef SCAN_BLANK_EN
                ST_BLANK: begin
                    // DIV > BLANK, so the blank window always ends before the slot does.
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                    if (cnt_r == BLANK_LAST) begin
                        state_nxt_s = ST_DRIVE;
                    end else begin
                        state_nxt_s = ST_BLANK;
                    end
                end
`endif
                ST_DRIVE: begin
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = SLOT_START;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        if (sel_r == LAST_SEL) begin
                            sel_nxt_s        = 3'd0;
                            frame_done_nxt_s = 1'b1;
                        end else begin
                            sel_nxt_s = sel_r + 3'd1;
                        end
                    end else begin
                        state_nxt_s = ST_DRIVE;
                        cnt_nxt_s   = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    sel_nxt_s   = 3'd0;
                end
            endcase
        end
        // The enable is registered from the next state, so sel and sel_en move on the same edge.
        sel_en_nxt_s = (state_nxt_s == ST_DRIVE);
    end

    // State and output registers. An asynchronous reset parks the scanner in idle with outputs dark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            sel_r        <= 3'd0;
            sel_en_r     <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            sel_r        <= sel_nxt_s;
            sel_en_r     <= sel_en_nxt_s;
            frame_done_r <= frame_done_nxt_s;
        end
    end

    assign sel        = sel_r;
    assign sel_en     = sel_en_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Directed bench for dec_scan_ctrl. It uses a three-slot scanner and a one-slot scanner,
// both with DIV=4 and BLANK=1. The expected sel_en follows SCAN_BLANK_EN as seen by the compile.
module tb_dec_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       run;
    logic [2:0] sel3;
    logic       en3;
    logic       fd3;
    logic [2:0] sel1;
    logic       en1;
    logic       fd1;

    int n_checks;
    int n_pass;

`ifdef SCAN_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    // Expected values for clocks 1..16 after a start. Clock k is sampled at the negedge after posedge k.
    int exp_sel3 [1:16] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0, 0, 0, 0};
    bit exp_fd3  [1:16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    bit exp_fd1  [1:16] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    bit exp_enb  [1:16] = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1};

    dec_scan_ctrl #(.DIV(4), .NUM_DIG(3), .BLANK(1), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .sel        (sel3),
        .sel_en     (en3),
        .frame_done (fd3)
    );

    dec_scan_ctrl #(.DIV(4), .NUM_DIG(1), .BLANK(1), .CNT_W(16)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .sel        (sel1),
        .sel_en     (en1),
        .frame_done (fd1)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs of a dec3to8 decoder driven by sel/sel_en.
    function automatic logic [7:0] dec_model(input logic [2:0] s, input logic e);
        logic [7:0] one;
        one = 8'd1;
        return e ? (one << s) : 8'd0;
    endfunction

    task automatic check_clock(input string phase, input int k, input bit chk1);
        bit exp_en;
        exp_en = BLANK_ON ? exp_enb[k] : 1'b1;
        check($sformatf("%s sel3 k%0d", phase, k), 32'(sel3), exp_sel3[k]);
        check($sformatf("%s en3 k%0d", phase, k), 32'(en3), 32'(exp_en));
        check($sformatf("%s fd3 k%0d", phase, k), 32'(fd3), 32'(exp_fd3[k]));
        check($sformatf("%s dec k%0d", phase, k), 32'(dec_model(sel3, en3)),
              32'(dec_model(3'(exp_sel3[k]), exp_en)));
        if (chk1) begin
            check($sformatf("%s sel1 k%0d", phase, k), 32'(sel1), 32'd0);
            check($sformatf("%s en1 k%0d", phase, k), 32'(en1), 32'(exp_en));
            check($sformatf("%s fd1 k%0d", phase, k), 32'(fd1), 32'(exp_fd1[k]));
        end else begin
            check($sformatf("%s sel1 k%0d", phase, k), 32'(sel1), 32'd0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        run      = 1'b0;

        // Reset state, sampled between edges.
        #250;
        check("rst sel3", 32'(sel3), 32'd0);
        check("rst en3", 32'(en3), 32'd0);
        check("rst fd3", 32'(fd3), 32'd0);
        check("rst sel1", 32'(sel1), 32'd0);
        check("rst en1", 32'(en1), 32'd0);
        check("rst fd1", 32'(fd1), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle en3", 32'(en3), 32'd0);
        check("idle sel3", 32'(sel3), 32'd0);

        // Start: four clocks per slot, and frame_done only on the wrap at clock 13.
        run = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check_clock("run", k, 1'b1);
        end

        // Clocks 17..19 are slot 1 with cnt 0..2. Drop run at clock 19, which is mid-slot.
        for (int k = 17; k <= 19; k++) begin
            @(negedge clk);
            check($sformatf("pre-stop sel3 k%0d", k), 32'(sel3), 32'd1);
        end
        run = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("stop sel3 h%0d", k), 32'(sel3), 32'd0);
            check($sformatf("stop en3 h%0d", k), 32'(en3), 32'd0);
            check($sformatf("stop fd3 h%0d", k), 32'(fd3), 32'd0);
        end

        // Restart from slot 0. frame_done stays low until a real wrap.
        run = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_clock("restart", k, 1'b1);
        end

        // Asynchronous reset mid-run: the outputs clear before the next rising edge.
        #50;
        rst = 1'b1;
        #1;
        check("async rst sel3", 32'(sel3), 32'd0);
        check("async rst en3", 32'(en3), 32'd0);
        check("async rst fd3", 32'(fd3), 32'd0);
        check("async rst en1", 32'(en1), 32'd0);
        @(negedge clk);
        check("rst held sel3", 32'(sel3), 32'd0);
        rst = 1'b0;
        run = 1'b0;
        @(negedge clk);
        check("post rst idle en3", 32'(en3), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
